mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: number of consecutive cycles a fetch request may be denied before fetch is forced to win.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_if_req  input  1  instruction fetch request, held until granted.
REQ-005 SHALL have port i_if_addr  input  30  fetch word address.
REQ-006 SHALL have port o_if_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port o_if_rvalid  output  1  fetch read data valid.
REQ-008 SHALL have port o_if_rdata  output  32  fetch read data.
REQ-009 SHALL have port i_ls_req  input  1  load/store request, held until granted.
REQ-010 SHALL have port i_ls_we  input  1  store (1) or load (0).
REQ-011 SHALL have port i_ls_addr  input  30  load/store word address.
REQ-012 SHALL have port i_ls_wdata  input  32  store data.
REQ-013 SHALL have port i_ls_mask  input  4  store byte mask.
REQ-014 SHALL have port o_ls_gnt  output  1  load/store request accepted this cycle.
REQ-015 SHALL have port o_ls_rvalid  output  1  load data valid.
REQ-016 SHALL have port o_ls_rdata  output  32  load data.
REQ-017 SHALL have ports o_mem_addr (output, 30), o_mem_data (output, 32), o_mem_we (output, 1), o_mem_mask (output, 4) and i_mem_data (input, 32): the shared single-port memory with 1-cycle synchronous read.

Function
REQ-018 SHALL grant at most one requester per cycle; the grant is combinational, in the same cycle as the request.
REQ-019 SHALL grant to the requester alone when only one requests.
REQ-020 SHALL, when both request, grant load/store, unless starve_cnt == STARVE_LIMIT, in which case it SHALL grant fetch.
REQ-021 SHALL keep a starve_cnt of $clog2(STARVE_LIMIT+1) bits.
- Increments when i_if_req && !o_if_gnt.
- Saturates at STARVE_LIMIT.
- Clears to 0 on o_if_gnt or !i_if_req.
REQ-022 SHALL drive the memory outputs from the granted requester.
- Fetch grant: o_mem_we=0, o_mem_mask=0, o_mem_data=0.
- No grant: all memory outputs 0.
REQ-023 SHALL record a read owner tag (NONE/IF/LS) at each clock edge.
- IF on a fetch grant; LS on a load grant.
- NONE on a store grant or no grant.
REQ-024 SHALL assert the owner's rvalid in the cycle after the read grant, with rdata = i_mem_data; the non-owner's rdata SHALL be 0.
REQ-025 SHALL never assert rvalid for a store.
REQ-026 SHALL make back-to-back grants with no bubble; a grant in cycle N and rvalid for grant N-1 coexist in cycle N.
REQ-027 SHALL NOT assert o_*_gnt when the corresponding i_*_req is low.

Reset
REQ-028 SHALL, while rst_n is low, immediately force starve_cnt=0, owner tag=NONE, and o_if_rvalid=o_ls_rvalid=0.
REQ-029 SHALL discard a read granted in the cycle before reset asserts; no rvalid appears after reset is released.
REQ-030 SHALL be able to grant in the first clock after rst_n rises.

Verification
REQ-031 Fetch only at addr 0x10, memory word 0x00500093 -> o_if_gnt=1 in the same cycle; next cycle o_if_rvalid=1, o_if_rdata=0x00500093, o_ls_rvalid=0.
REQ-032 Both request continuously, STARVE_LIMIT=4 -> LS granted cycles 0-3, IF granted cycle 4, LS granted again cycle 5; starve_cnt reads 0,1,2,3,4,0.
REQ-033 Store addr 0x20, data 0xDEADBEEF, mask 0x3 -> o_mem_we=1, o_mem_mask=0x3 in the grant cycle; no rvalid on either side the following cycle.
REQ-034 Alternating load (addr 0x8) and fetch (addr 0x0) on consecutive cycles -> rvalid/rdata routed to the correct side each cycle with no gap; the other side's rdata=0.
REQ-035 Load granted, rst_n pulsed low mid-cycle before the next edge -> o_ls_rvalid stays 0, and after release starve_cnt=0 and memory outputs are 0 when idle.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates a shared single-port memory (1-cycle synchronous read) between
//   an instruction-fetch port and a load/store port.
//
//   Load/store wins contention. After fetch has been denied STARVE_LIMIT
//   consecutive cycles, fetch wins once.
//
//   Grants are combinational, in the same cycle as the request. Read data
//   returns one cycle later and is steered to the requester recorded in the
//   owner tag. Back-to-back grants run with no bubble.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_if_req / i_if_addr       fetch request and word address
//   o_if_gnt                   fetch accepted this cycle
//   o_if_rvalid / o_if_rdata   fetch read return
//   i_ls_req / i_ls_we         load/store request, 1 = store
//   i_ls_addr / i_ls_wdata     load/store word address and store data
//   i_ls_mask                  store byte mask
//   o_ls_gnt                   load/store accepted this cycle
//   o_ls_rvalid / o_ls_rdata   load read return
//   o_mem_addr / o_mem_data    shared memory address and write data
//   o_mem_we / o_mem_mask      shared memory write enable and byte mask
//   i_mem_data                 shared memory read data (one cycle after address)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_if_req,
  input  logic [29:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [29:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_mask,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic [29:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_mask,
  input  logic [31:0] i_mem_data
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  // Which port owns the read data returning in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  owner_t        owner_reg, owner_next;
  logic [CW-1:0] starve_cnt_reg, starve_cnt_next;
  logic          starved;

  assign starved = (starve_cnt_reg == LIMIT);

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg      <= OWN_NONE;
      starve_cnt_reg <= '0;
    end else begin
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Grant, memory drive, starvation counter and owner tag
  always_comb begin
    o_if_gnt        = 1'b0;
    o_ls_gnt        = 1'b0;
    o_mem_addr      = '0;
    o_mem_data      = '0;
    o_mem_we        = 1'b0;
    o_mem_mask      = '0;
    owner_next      = OWN_NONE;
    starve_cnt_next = starve_cnt_reg;

    // Fetch wins if load/store is idle or fetch has waited long enough.
    if (i_if_req && (!i_ls_req || starved)) begin
      o_if_gnt = 1'b1;
    end else if (i_ls_req) begin
      o_ls_gnt = 1'b1;
    end

    if (o_if_gnt) begin
      o_mem_addr = i_if_addr;
      owner_next = OWN_IF;
    end else if (o_ls_gnt) begin
      o_mem_addr = i_ls_addr;
      o_mem_data = i_ls_wdata;
      o_mem_we   = i_ls_we;
      o_mem_mask = i_ls_mask;
      // A store produces no read return.
      owner_next = i_ls_we ? OWN_NONE : OWN_LS;
    end

    // Count consecutive denied fetch cycles, saturating at the limit.
    if (!i_if_req || o_if_gnt) begin
      starve_cnt_next = '0;
    end else if (!starved) begin
      starve_cnt_next = starve_cnt_reg + CW'(1);
    end
  end

  // Read return steering; the non-owner sees zero data.
  assign o_if_rvalid = (owner_reg == OWN_IF);
  assign o_ls_rvalid = (owner_reg == OWN_LS);
  assign o_if_rdata  = o_if_rvalid ? i_mem_data : 32'd0;
  assign o_ls_rdata  = o_ls_rvalid ? i_mem_data : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed self-checking bench for mem_arbiter. A small byte-masked memory
//   model with 1-cycle read latency sits on the shared memory port. Inputs are
//   driven 1 time unit after the rising edge. Combinational outputs are checked
//   1 unit later, and registered outputs are checked right after each edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_if_req;
  logic [29:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req;
  logic        i_ls_we;
  logic [29:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [3:0]  i_ls_mask;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic [29:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic        o_mem_we;
  logic [3:0]  o_mem_mask;
  logic [31:0] i_mem_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_if_req   (i_if_req),
    .i_if_addr  (i_if_addr),
    .o_if_gnt   (o_if_gnt),
    .o_if_rvalid(o_if_rvalid),
    .o_if_rdata (o_if_rdata),
    .i_ls_req   (i_ls_req),
    .i_ls_we    (i_ls_we),
    .i_ls_addr  (i_ls_addr),
    .i_ls_wdata (i_ls_wdata),
    .i_ls_mask  (i_ls_mask),
    .o_ls_gnt   (o_ls_gnt),
    .o_ls_rvalid(o_ls_rvalid),
    .o_ls_rdata (o_ls_rdata),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_mem_we   (o_mem_we),
    .o_mem_mask (o_mem_mask),
    .i_mem_data (i_mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared memory model: byte-masked write, registered read
  always @(posedge clk) begin
    if (o_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (o_mem_mask[b]) mem[o_mem_addr[5:0]][8*b +: 8] <= o_mem_data[8*b +: 8];
      end
    end
    i_mem_data <= mem[o_mem_addr[5:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_if_req   = 1'b0;
    i_if_addr  = '0;
    i_ls_req   = 1'b0;
    i_ls_we    = 1'b0;
    i_ls_addr  = '0;
    i_ls_wdata = '0;
    i_ls_mask  = '0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    #3;
    $display("txn reset: rst_n low");
    checks++; if (o_if_gnt !== 1'b0) begin errors++; $display("FAIL reset_if_gnt got=%0b exp=0", o_if_gnt); end
    checks++; if (o_ls_gnt !== 1'b0) begin errors++; $display("FAIL reset_ls_gnt got=%0b exp=0", o_ls_gnt); end
    checks++; if (o_if_rvalid !== 1'b0) begin errors++; $display("FAIL reset_if_rvalid got=%0b exp=0", o_if_rvalid); end
    checks++; if (o_ls_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ls_rvalid got=%0b exp=0", o_ls_rvalid); end
    checks++; if (o_mem_addr !== 30'd0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", o_mem_addr); end
    checks++; if (dut.starve_cnt_reg !== 3'd0) begin errors++; $display("FAIL reset_starve got=%0d exp=0", dut.starve_cnt_reg); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_fetch_only();
    i_if_req  = 1'b1;
    i_if_addr = 30'h10;
    #1;
    $display("txn fetch addr=0x10");
    checks++; if (o_if_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt got=%0b exp=1", o_if_gnt); end
    checks++; if (o_ls_gnt !== 1'b0) begin errors++; $display("FAIL fetch_ls_gnt got=%0b exp=0", o_ls_gnt); end
    checks++; if (o_mem_addr !== 30'h10) begin errors++; $display("FAIL fetch_mem_addr got=%h exp=10", o_mem_addr); end
    checks++; if (o_mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_we got=%0b exp=0", o_mem_we); end
    tick();
    idle_inputs();
    #1;
    checks++; if (o_if_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid got=%0b exp=1", o_if_rvalid); end
    checks++; if (o_if_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_rdata got=%h exp=00500093", o_if_rdata); end
    checks++; if (o_ls_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_ls_rvalid got=%0b exp=0", o_ls_rvalid); end
    checks++; if (o_ls_rdata !== 32'd0) begin errors++; $display("FAIL fetch_ls_rdata got=%h exp=0", o_ls_rdata); end
    checks++; if (o_if_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt_noreq got=%0b exp=0", o_if_gnt); end
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_starvation();
    i_if_req  = 1'b1;
    i_if_addr = 30'h10;
    i_ls_req  = 1'b1;
    i_ls_we   = 1'b0;
    i_ls_addr = 30'h8;
    for (int c = 0; c < 6; c++) begin
      #1;
      $display("txn contend cycle=%0d starve=%0d if_gnt=%0b ls_gnt=%0b", c, dut.starve_cnt_reg, o_if_gnt, o_ls_gnt);
      checks++; if (dut.starve_cnt_reg !== 3'(c % 5)) begin errors++; $display("FAIL starve_cnt c=%0d got=%0d exp=%0d", c, dut.starve_cnt_reg, c % 5); end
      checks++; if (o_if_gnt !== (c == 4)) begin errors++; $display("FAIL starve_if_gnt c=%0d got=%0b exp=%0b", c, o_if_gnt, c == 4); end
      checks++; if (o_ls_gnt !== (c != 4)) begin errors++; $display("FAIL starve_ls_gnt c=%0d got=%0b exp=%0b", c, o_ls_gnt, c != 4); end
      checks++; if (o_if_rvalid !== (c == 5)) begin errors++; $display("FAIL starve_if_rvalid c=%0d got=%0b exp=%0b", c, o_if_rvalid, c == 5); end
      checks++; if (o_ls_rvalid !== (c >= 1 && c != 5)) begin errors++; $display("FAIL starve_ls_rvalid c=%0d got=%0b exp=%0b", c, o_ls_rvalid, c >= 1 && c != 5); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_store();
    i_ls_req   = 1'b1;
    i_ls_we    = 1'b1;
    i_ls_addr  = 30'h20;
    i_ls_wdata = 32'hDEADBEEF;
    i_ls_mask  = 4'h3;
    #1;
    $display("txn store addr=0x20 data=deadbeef mask=3");
    checks++; if (o_ls_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt got=%0b exp=1", o_ls_gnt); end
    checks++; if (o_mem_we !== 1'b1) begin errors++; $display("FAIL store_we got=%0b exp=1", o_mem_we); end
    checks++; if (o_mem_mask !== 4'h3) begin errors++; $display("FAIL store_mask got=%h exp=3", o_mem_mask); end
    checks++; if (o_mem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL store_data got=%h exp=deadbeef", o_mem_data); end
    checks++; if (o_mem_addr !== 30'h20) begin errors++; $display("FAIL store_addr got=%h exp=20", o_mem_addr); end
    tick();
    idle_inputs();
    #1;
    checks++; if (o_ls_rvalid !== 1'b0) begin errors++; $display("FAIL store_ls_rvalid got=%0b exp=0", o_ls_rvalid); end
    checks++; if (o_if_rvalid !== 1'b0) begin errors++; $display("FAIL store_if_rvalid got=%0b exp=0", o_if_rvalid); end
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Alternating load / fetch, one request per cycle, no idle gaps
  task automatic test_back_to_back();
    logic        is_fetch [4];
    logic [29:0] addr     [4];
    logic [31:0] data     [4];
    is_fetch = '{1'b0, 1'b1, 1'b0, 1'b1};
    addr     = '{30'h8, 30'h0, 30'h20, 30'h10};
    data     = '{32'h11223344, 32'hAAAA5555, 32'h0000BEEF, 32'h00500093};
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      if (i < 4) begin
        if (is_fetch[i]) begin
          i_if_req   = 1'b1;
          i_if_addr  = addr[i];
          // Load/store fields carry junk that must not leak onto the memory port.
          i_ls_we    = 1'b1;
          i_ls_wdata = 32'hCAFEF00D;
          i_ls_mask  = 4'hF;
        end else begin
          i_ls_req  = 1'b1;
          i_ls_addr = addr[i];
        end
      end
      #1;
      if (i < 4) begin
        $display("txn b2b i=%0d %s addr=%h", i, is_fetch[i] ? "fetch" : "load", addr[i]);
        checks++; if (o_if_gnt !== is_fetch[i]) begin errors++; $display("FAIL b2b_if_gnt i=%0d got=%0b exp=%0b", i, o_if_gnt, is_fetch[i]); end
        checks++; if (o_ls_gnt !== !is_fetch[i]) begin errors++; $display("FAIL b2b_ls_gnt i=%0d got=%0b exp=%0b", i, o_ls_gnt, !is_fetch[i]); end
        checks++; if (o_mem_we !== 1'b0) begin errors++; $display("FAIL b2b_mem_we i=%0d got=%0b exp=0", i, o_mem_we); end
        if (is_fetch[i]) begin
          checks++; if ({o_mem_data, o_mem_mask} !== 36'd0) begin errors++; $display("FAIL b2b_fetch_wfields i=%0d got data=%h mask=%h exp=0", i, o_mem_data, o_mem_mask); end
        end
      end
      if (i > 0) begin
        checks++; if (o_if_rvalid !== is_fetch[i-1]) begin errors++; $display("FAIL b2b_if_rvalid i=%0d got=%0b exp=%0b", i, o_if_rvalid, is_fetch[i-1]); end
        checks++; if (o_ls_rvalid !== !is_fetch[i-1]) begin errors++; $display("FAIL b2b_ls_rvalid i=%0d got=%0b exp=%0b", i, o_ls_rvalid, !is_fetch[i-1]); end
        checks++; if (o_if_rdata !== (is_fetch[i-1] ? data[i-1] : 32'd0)) begin errors++; $display("FAIL b2b_if_rdata i=%0d got=%h exp=%h", i, o_if_rdata, is_fetch[i-1] ? data[i-1] : 32'd0); end
        checks++; if (o_ls_rdata !== (is_fetch[i-1] ? 32'd0 : data[i-1])) begin errors++; $display("FAIL b2b_ls_rdata i=%0d got=%h exp=%h", i, o_ls_rdata, is_fetch[i-1] ? 32'd0 : data[i-1]); end
      end
      tick();
    end
    idle_inputs();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    i_if_req  = 1'b1;
    i_if_addr = 30'h10;
    i_ls_req  = 1'b1;
    i_ls_we   = 1'b0;
    i_ls_addr = 30'h8;
    #1;
    checks++; if (o_ls_gnt !== 1'b1) begin errors++; $display("FAIL rmid_ls_gnt0 got=%0b exp=1", o_ls_gnt); end
    tick();
    #1;
    $display("txn load granted, reset pulsed mid-cycle");
    checks++; if (dut.starve_cnt_reg !== 3'd1) begin errors++; $display("FAIL rmid_starve_pre got=%0d exp=1", dut.starve_cnt_reg); end
    checks++; if (o_ls_gnt !== 1'b1) begin errors++; $display("FAIL rmid_ls_gnt1 got=%0b exp=1", o_ls_gnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (dut.starve_cnt_reg !== 3'd0) begin errors++; $display("FAIL rmid_starve_async got=%0d exp=0", dut.starve_cnt_reg); end
    checks++; if (o_ls_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_ls_rvalid_async got=%0b exp=0", o_ls_rvalid); end
    idle_inputs();
    tick();
    checks++; if (o_ls_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_ls_rvalid_inrst got=%0b exp=0", o_ls_rvalid); end
    rst_n = 1'b1;
    #1;
    checks++; if (o_ls_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_ls_rvalid_post got=%0b exp=0", o_ls_rvalid); end
    checks++; if (o_if_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_if_rvalid_post got=%0b exp=0", o_if_rvalid); end
    checks++; if (dut.starve_cnt_reg !== 3'd0) begin errors++; $display("FAIL rmid_starve_post got=%0d exp=0", dut.starve_cnt_reg); end
    checks++; if ({o_mem_addr, o_mem_data, o_mem_we, o_mem_mask} !== 67'd0) begin errors++; $display("FAIL rmid_mem_idle got addr=%h data=%h we=%0b mask=%h exp=0", o_mem_addr, o_mem_data, o_mem_we, o_mem_mask); end
    // First clock after release must already grant.
    i_if_req  = 1'b1;
    i_if_addr = 30'h0;
    #1;
    $display("txn fetch after reset release addr=0x0");
    checks++; if (o_if_gnt !== 1'b1) begin errors++; $display("FAIL rmid_first_gnt got=%0b exp=1", o_if_gnt); end
    tick();
    idle_inputs();
    #1;
    checks++; if (o_if_rvalid !== 1'b1) begin errors++; $display("FAIL rmid_first_rvalid got=%0b exp=1", o_if_rvalid); end
    checks++; if (o_if_rdata !== 32'hAAAA5555) begin errors++; $display("FAIL rmid_first_rdata got=%h exp=aaaa5555", o_if_rdata); end
    tick();
  endtask

  // -------------------------------------------------------------------------
  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'd0;
    mem[16] = 32'h00500093;
    mem[8]  = 32'h11223344;
    mem[0]  = 32'hAAAA5555;
    rst_n = 1'b0;
    idle_inputs();

    test_reset();
    tick();
    test_fetch_only();
    test_starvation();
    test_store();
    test_back_to_back();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
